mem_arbiter: RTL and testbench

Arbitrates the single RAM port between the instruction cache and the data cache of one core, sitting between the cache pair and the RAM model. Holds a registered grant for the duration of each RAM access, steers address/data/enables from the granted cache to RAM, and returns the load word and wait status to the requester. The dcache has priority, with a starvation limit that guarantees instruction fetch progress.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/arb_starve_counter.sv | 28 ++
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM handshake state and the memory arbiter FSM state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;

  // dcache first, unless the icache has been held off long enough.
  function automatic arb_state_t arb_pick(input logic dreq, input logic ireq,
                                          input logic starved);
    if (dreq && !(ireq && starved)) return DGRANT;
    else if (ireq)                  return IGRANT;
    return IDLE;
  endfunction
endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of dcache completions that overtook a pending icache read.
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)                            cnt_nxt = '0;
    else if (inc && (cnt != W'(MAX)))   cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) cnt <= '0;
    else       cnt <= cnt_nxt;

  // Look-ahead: the arbiter decides on the edge that performs this update,
  // so the icache wins right after the MAX-th overtaking completion.
  assign sat = (cnt_nxt == W'(MAX));
endmodule

// File: rtl/mem_arbiter.sv
// Single RAM port shared by icache and dcache; dcache priority with a
// starvation bound on instruction fetch.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);
  arb_state_t state, nstate, pick;
  logic       dreq, icomp, dcomp, starved;

  assign dreq  = dREN | dWEN;
  assign icomp = (state == IGRANT) && iREN && (ramstate == ACCESS);
  assign dcomp = (state == DGRANT) && dreq && (ramstate == ACCESS);

  arb_starve_counter #(.MAX(STARVE_LIMIT)) u_starve (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (dcomp & iREN),
    .clr  (icomp | ~iREN),
    .sat  (starved)
  );

  assign pick = arb_pick(dreq, iREN, starved);

  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) state <= IDLE;
    else       state <= nstate;

  // Re-arbitrate on completion or withdrawal; otherwise hold the grant
  // (BUSY/FREE/ERROR all just retry).
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = pick;
      IGRANT:  if (!iREN || icomp) nstate = pick;
      DGRANT:  if (!dreq || dcomp) nstate = pick;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (icomp) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (dcomp) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle reference model plus literal checks.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIM = 4;

  logic      CLK = 1'b0;
  logic      nRST = 1'b0;
  logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t     iaddr = '0, daddr = '0, dstore = '0;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore, ramload;
  ramstate_t rs = FREE;

  int checks = 0, passes = 0, fails = 0;

  always #5 CLK = ~CLK;

  function automatic word_t memf(input word_t a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  assign ramload = memf(ramaddr);

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(rs)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 icache, 2 dcache) and how
  // many dcache completions have overtaken the current icache request.
  int owner = 0, starve = 0;
  initial forever begin
    logic  e_ren, e_wen, e_iw, e_dw, ic, dc, done, dreq, acc;
    word_t e_addr, e_store, e_il, e_dl;
    @(negedge CLK);
    #3;
    e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
    e_iw = 1; e_dw = 1; e_il = 0; e_dl = 0;
    ic = 0; dc = 0; done = 1;
    dreq = dREN | dWEN;
    acc  = (rs == ACCESS);
    if (nRST && owner == 1) begin
      e_ren = iREN; e_addr = iaddr;
      ic = iREN && acc; done = !iREN || acc;
      if (ic) begin e_iw = 0; e_il = memf(iaddr); end
    end else if (nRST && owner == 2) begin
      e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
      dc = dreq && acc; done = !dreq || acc;
      if (dc) begin e_dw = 0; e_dl = memf(daddr); end
    end
    chk("m_ramREN", ramREN, e_ren);
    chk("m_ramWEN", ramWEN, e_wen);
    chk("m_ramaddr", ramaddr, e_addr);
    chk("m_ramstore", ramstore, e_store);
    chk("m_iwait", iwait, e_iw);
    chk("m_dwait", dwait, e_dw);
    chk("m_iload", iload, e_il);
    chk("m_dload", dload, e_dl);
    if (!nRST) begin
      owner = 0; starve = 0;
    end else begin
      if (ic || !iREN) starve = 0;
      else if (dc)     starve = (starve + 1 > LIM) ? LIM : starve + 1;
      if (done) owner = (dreq && !(iREN && starve == LIM)) ? 2 : (iREN ? 1 : 0);
    end
  end

  task automatic cyc; @(posedge CLK); #1; endtask
  task automatic smp; @(negedge CLK); endtask
  task automatic quiet;
    iREN = 0; dREN = 0; dWEN = 0; rs = FREE;
    cyc(); cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    // reset state
    smp();
    chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0); chk("rst_iload", iload, 0);
    cyc(); nRST = 1;

    // icache fetch from idle, RAM ready at once
    iREN = 1; iaddr = 32'h40; rs = ACCESS;
    smp(); chk("t1_idle_ren", ramREN, 0); chk("t1_idle_iwait", iwait, 1);
    cyc(); smp();
    chk("t1_ramREN", ramREN, 1); chk("t1_ramaddr", ramaddr, 32'h40);
    chk("t1_iwait", iwait, 0); chk("t1_iload", iload, memf(32'h40));
    cyc(); quiet();

    // write beats a simultaneous fetch; fetch served once the write is gone
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; iREN = 1; iaddr = 32'h80; rs = ACCESS;
    cyc(); smp();
    chk("t2_ramWEN", ramWEN, 1); chk("t2_ramREN", ramREN, 0);
    chk("t2_ramaddr", ramaddr, 32'h100); chk("t2_ramstore", ramstore, 32'hDEADBEEF);
    chk("t2_dwait", dwait, 0); chk("t2_iwait", iwait, 1);
    cyc(); dWEN = 0;
    smp(); chk("t2_wd_wen", ramWEN, 0); chk("t2_wd_dwait", dwait, 1);
    cyc(); smp();
    chk("t2_i_ren", ramREN, 1); chk("t2_i_addr", ramaddr, 32'h80); chk("t2_i_iwait", iwait, 0);
    quiet();

    // starvation bound: D D D D I repeating, no bubbles
    dREN = 1; daddr = 32'h600; iREN = 1; iaddr = 32'h700; rs = ACCESS;
    for (int k = 0; k < 10; k++) begin
      cyc(); smp();
      chk($sformatf("t3_icomp%0d", k), !iwait, (k % 5) == 4);
      chk($sformatf("t3_dcomp%0d", k), !dwait, (k % 5) != 4);
    end
    quiet();

    // BUSY, ERROR, BUSY then ACCESS during a dcache read
    dREN = 1; daddr = 32'h200; rs = BUSY;
    cyc();
    for (int k = 0; k < 4; k++) begin
      rs = (k == 3) ? ACCESS : ((k == 1) ? ERROR : BUSY);
      smp();
      chk($sformatf("t4_dwait%0d", k), dwait, k != 3);
      chk($sformatf("t4_addr%0d", k), ramaddr, 32'h200);
      if (k != 3) cyc();
    end
    chk("t4_dload", dload, memf(32'h200));
    cyc(); quiet();

    // fetch withdrawn while RAM busy; dcache takes over next cycle
    iREN = 1; iaddr = 32'h300; rs = BUSY;
    cyc(); smp();
    chk("t5_ren", ramREN, 1); chk("t5_addr", ramaddr, 32'h300); chk("t5_iwait", iwait, 1);
    cyc(); iREN = 0; dREN = 1; daddr = 32'h400;
    smp(); chk("t5_wd_ren", ramREN, 0); chk("t5_wd_iwait", iwait, 1);
    cyc(); smp();
    chk("t5_d_ren", ramREN, 1); chk("t5_d_addr", ramaddr, 32'h400); chk("t5_d_dwait", dwait, 1);
    quiet();

    // asynchronous reset in the middle of a dcache write
    dWEN = 1; daddr = 32'h500; dstore = 32'h1; rs = BUSY;
    cyc(); smp(); chk("t6_wen_pre", ramWEN, 1);
    #1 nRST = 0;
    #1;
    chk("t6_wen", ramWEN, 0); chk("t6_ren", ramREN, 0); chk("t6_addr", ramaddr, 0);
    dWEN = 0;
    cyc(); nRST = 1;
    smp(); chk("t6_idle_dwait", dwait, 1); chk("t6_idle_wen", ramWEN, 0);
    cyc(); cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
